// File: rtl/rename_register_file_pkg.sv
// Shared widths, constants and types for the rename register file slice.
package rename_register_file_pkg;

    localparam int TAG_W     = 4;
    localparam int REG_COUNT = 32;
    localparam int WORD_W    = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] reg_index_t;
    typedef logic [TAG_W-1:0]     rob_tag_t;

    // Tag 0 means "no in-flight producer": the stored value is final.
    localparam rob_tag_t   NULL_TAG       = '0;
    localparam word_t      ZERO_WORD      = '0;
    localparam reg_index_t ZERO_REG_INDEX = '0;

endpackage

// File: rtl/rename_register_file_if.sv
// Decoder, commit and rollback signals between the core and the rename register file.
interface rename_register_file_if;
    import rename_register_file_pkg::*;

    logic       rollback_in;

    logic       dec_issue_in;
    reg_index_t dec_rd_in;
    rob_tag_t   dec_tag_in;
    reg_index_t dec_rs1_in;
    reg_index_t dec_rs2_in;
    word_t      dec_Vj_out;
    word_t      dec_Vk_out;
    rob_tag_t   dec_Qj_out;
    rob_tag_t   dec_Qk_out;

    logic       commit_rf_signal_in;
    reg_index_t commit_target_in;
    rob_tag_t   commit_tag_in;
    word_t      commit_data_in;

    // Core side: decoder / ROB drive requests and consume operands.
    modport master (
        output rollback_in,
        output dec_issue_in, dec_rd_in, dec_tag_in, dec_rs1_in, dec_rs2_in,
        input  dec_Vj_out, dec_Vk_out, dec_Qj_out, dec_Qk_out,
        output commit_rf_signal_in, commit_target_in, commit_tag_in, commit_data_in
    );

    // Register file side.
    modport slave (
        input  rollback_in,
        input  dec_issue_in, dec_rd_in, dec_tag_in, dec_rs1_in, dec_rs2_in,
        output dec_Vj_out, dec_Vk_out, dec_Qj_out, dec_Qk_out,
        input  commit_rf_signal_in, commit_target_in, commit_tag_in, commit_data_in
    );

endinterface

// File: rtl/rename_register_file_rf_read_port.sv
// One operand read port: x0 forcing, same-cycle commit bypass, else stored value/tag.
module rf_read_port
    import rename_register_file_pkg::*;
(
    input  reg_index_t rs,
    input  word_t      value_rd,
    input  rob_tag_t   tag_rd,
    input  logic       commit_valid,
    input  reg_index_t commit_target,
    input  rob_tag_t   commit_tag,
    input  word_t      commit_data,
    output word_t      v,
    output rob_tag_t   q
);

    // Select operand source; bypass only when the committing entry is still the
    // register's current producer, otherwise a younger producer owns the tag.
    always_comb begin
        v = value_rd;
        q = tag_rd;
        if (rs == ZERO_REG_INDEX) begin
            v = ZERO_WORD;
            q = NULL_TAG;
        end else if (commit_valid && (commit_target == rs) && (tag_rd == commit_tag)) begin
            v = commit_data;
            q = NULL_TAG;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with rename tags: commits retire values, issues
// claim destination tags, rollback drops every pending tag.
module rename_register_file
    import rename_register_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    rename_register_file_if.slave bus
);

    word_t    value_q [REG_COUNT];
    rob_tag_t tag_q   [REG_COUNT];

    logic commit_wr;
    logic issue_wr;

    assign commit_wr = bus.commit_rf_signal_in && (bus.commit_target_in != ZERO_REG_INDEX);
    assign issue_wr  = bus.dec_issue_in && (bus.dec_rd_in != ZERO_REG_INDEX);

    // Value array: only commits write; a commit during rollback still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= ZERO_WORD;
            end
        end else if (commit_wr) begin
            value_q[bus.commit_target_in] <= bus.commit_data_in;
        end
    end

    // Tag array: rollback clears all; otherwise commit clears a matching tag and
    // a same-cycle issue to the same register overrides that clear.
    always_ff @(posedge clk) begin
        if (rst || bus.rollback_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                tag_q[i] <= NULL_TAG;
            end
        end else begin
            if (commit_wr && (tag_q[bus.commit_target_in] == bus.commit_tag_in)) begin
                tag_q[bus.commit_target_in] <= NULL_TAG;
            end
            if (issue_wr) begin
                tag_q[bus.dec_rd_in] <= bus.dec_tag_in;
            end
        end
    end

    rf_read_port u_read_rs1 (
        .rs            (bus.dec_rs1_in),
        .value_rd      (value_q[bus.dec_rs1_in]),
        .tag_rd        (tag_q[bus.dec_rs1_in]),
        .commit_valid  (bus.commit_rf_signal_in),
        .commit_target (bus.commit_target_in),
        .commit_tag    (bus.commit_tag_in),
        .commit_data   (bus.commit_data_in),
        .v             (bus.dec_Vj_out),
        .q             (bus.dec_Qj_out)
    );

    rf_read_port u_read_rs2 (
        .rs            (bus.dec_rs2_in),
        .value_rd      (value_q[bus.dec_rs2_in]),
        .tag_rd        (tag_q[bus.dec_rs2_in]),
        .commit_valid  (bus.commit_rf_signal_in),
        .commit_target (bus.commit_target_in),
        .commit_tag    (bus.commit_tag_in),
        .commit_data   (bus.commit_data_in),
        .v             (bus.dec_Vk_out),
        .q             (bus.dec_Qk_out)
    );

endmodule

// File: tb/tb_rename_register_file.sv
// Bench for rename_register_file: directed scenarios with literal expectations
// plus a per-cycle comparison against an array-based behavioural model.
module tb_rename_register_file;
    import rename_register_file_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   model_ok = 1'b0;

    logic [31:0] m_val [32];
    logic [3:0]  m_tag [32];

    rename_register_file_if bus ();

    rename_register_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.rollback_in         = 1'b0;
        bus.dec_issue_in        = 1'b0;
        bus.dec_rd_in           = '0;
        bus.dec_tag_in          = '0;
        bus.dec_rs1_in          = '0;
        bus.dec_rs2_in          = '0;
        bus.commit_rf_signal_in = 1'b0;
        bus.commit_target_in    = '0;
        bus.commit_tag_in       = '0;
        bus.commit_data_in      = '0;
    endtask

    // Advance to just after the next rising edge with all inputs idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input int rd, input int tag);
        bus.dec_issue_in = 1'b1;
        bus.dec_rd_in    = 5'(rd);
        bus.dec_tag_in   = 4'(tag);
    endtask

    task automatic commit(input int target, input int tag, input logic [31:0] data);
        bus.commit_rf_signal_in = 1'b1;
        bus.commit_target_in    = 5'(target);
        bus.commit_tag_in       = 4'(tag);
        bus.commit_data_in      = data;
    endtask

    task automatic read(input int rs1, input int rs2);
        bus.dec_rs1_in = 5'(rs1);
        bus.dec_rs2_in = 5'(rs2);
    endtask

    // Literal check of both ports, taken a little after inputs settle.
    task automatic lit(input string name, input logic [31:0] vj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic [3:0] qk);
        #2;
        checks++;
        if (bus.dec_Vj_out !== vj || bus.dec_Qj_out !== qj ||
            bus.dec_Vk_out !== vk || bus.dec_Qk_out !== qk) begin
            errors++;
            $display("FAIL %s: got Vj=%h Qj=%0d Vk=%h Qk=%0d, want Vj=%h Qj=%0d Vk=%h Qk=%0d",
                     name, bus.dec_Vj_out, bus.dec_Qj_out, bus.dec_Vk_out, bus.dec_Qk_out,
                     vj, qj, vk, qk);
        end
    endtask

    // Model read rule: x0 is zero; a commit from the current producer is
    // forwarded; otherwise the committed state is returned.
    function automatic void model_read(input int rs, output logic [31:0] v, output logic [3:0] q);
        if (rs == 0) begin
            v = 32'h0; q = 4'h0;
        end else if (bus.commit_rf_signal_in && int'(bus.commit_target_in) == rs &&
                     m_tag[rs] == bus.commit_tag_in) begin
            v = bus.commit_data_in; q = 4'h0;
        end else begin
            v = m_val[rs]; q = m_tag[rs];
        end
    endfunction

    // Model state update at each rising edge from the inputs presented that cycle.
    always @(posedge clk) begin
        int t, d;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 32'h0;
                m_tag[i] = 4'h0;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            t = int'(bus.commit_target_in);
            d = int'(bus.dec_rd_in);
            if (bus.commit_rf_signal_in && t != 0) begin
                m_val[t] = bus.commit_data_in;
            end
            if (bus.rollback_in) begin
                for (int i = 0; i < 32; i++) m_tag[i] = 4'h0;
            end else begin
                if (bus.commit_rf_signal_in && t != 0 && m_tag[t] == bus.commit_tag_in)
                    m_tag[t] = 4'h0;
                if (bus.dec_issue_in && d != 0)
                    m_tag[d] = bus.dec_tag_in;
            end
        end
    end

    // Per-cycle comparison of both read ports against the model.
    always @(negedge clk) begin
        logic [31:0] vj, vk;
        logic [3:0]  qj, qk;
        if (model_ok && !rst) begin
            model_read(int'(bus.dec_rs1_in), vj, qj);
            model_read(int'(bus.dec_rs2_in), vk, qk);
            checks++;
            if (bus.dec_Vj_out !== vj || bus.dec_Qj_out !== qj ||
                bus.dec_Vk_out !== vk || bus.dec_Qk_out !== qk) begin
                errors++;
                $display("FAIL model rs1=%0d rs2=%0d @%0t: got Vj=%h Qj=%0d Vk=%h Qk=%0d, want Vj=%h Qj=%0d Vk=%h Qk=%0d",
                         bus.dec_rs1_in, bus.dec_rs2_in, $time, bus.dec_Vj_out, bus.dec_Qj_out,
                         bus.dec_Vk_out, bus.dec_Qk_out, vj, qj, vk, qk);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        idle(); read(5, 0); lit("reset_x5_x0", 32'h0, 4'h0, 32'h0, 4'h0);

        // Issue then commit with bypass.
        cyc(); issue(5, 3);
        cyc(); read(5, 0); lit("x5_pending", 32'h0, 4'h3, 32'h0, 4'h0);
        cyc(); commit(5, 3, 32'h1234); read(5, 5); lit("x5_bypass", 32'h1234, 4'h0, 32'h1234, 4'h0);
        cyc(); read(5, 0); lit("x5_committed", 32'h1234, 4'h0, 32'h0, 4'h0);

        // Older commit must not clear a younger producer's tag.
        cyc(); issue(7, 2);
        cyc(); issue(7, 4);
        cyc(); commit(7, 2, 32'hAA); read(7, 0); lit("x7_no_bypass", 32'h0, 4'h4, 32'h0, 4'h0);
        cyc(); read(0, 7); lit("x7_value_keep_tag", 32'h0, 4'h0, 32'hAA, 4'h4);

        // Same-cycle issue and commit on x9: read sees old producer, bypassed.
        cyc(); issue(9, 5);
        cyc(); issue(9, 6); commit(9, 5, 32'h55); read(9, 9); lit("x9_issue_commit_bypass", 32'h55, 4'h0, 32'h55, 4'h0);
        cyc(); read(9, 0); lit("x9_issue_wins", 32'h55, 4'h6, 32'h0, 4'h0);

        // Rollback clears tags, keeps the same-cycle commit, drops the issue.
        cyc(); issue(1, 1);
        cyc(); issue(2, 2);
        cyc(); issue(3, 3);
        cyc(); bus.rollback_in = 1'b1; commit(1, 1, 32'h77); issue(4, 5); read(2, 1);
        lit("rollback_cycle_old_tags", 32'h0, 4'h2, 32'h77, 4'h0);
        cyc(); read(1, 4); lit("after_rollback_x1_x4", 32'h77, 4'h0, 32'h0, 4'h0);
        cyc(); read(2, 3); lit("after_rollback_x2_x3", 32'h0, 4'h0, 32'h0, 4'h0);
        cyc(); read(9, 7); lit("after_rollback_x9_x7", 32'h55, 4'h0, 32'hAA, 4'h0);

        // x0 writes ignored.
        cyc(); issue(0, 3); commit(0, 0, 32'hFFFF); read(0, 0); lit("x0_write_cycle", 32'h0, 4'h0, 32'h0, 4'h0);
        cyc(); read(0, 0); lit("x0_after_write", 32'h0, 4'h0, 32'h0, 4'h0);

        // Mixed traffic checked only against the model.
        for (int n = 0; n < 300; n++) begin
            cyc();
            if ($urandom_range(0, 1) == 1) issue($urandom_range(0, 7), $urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) commit($urandom_range(0, 7), $urandom_range(0, 15), $urandom);
            bus.rollback_in = ($urandom_range(0, 19) == 0);
            read($urandom_range(0, 7), $urandom_range(0, 7));
        end

        // Reset in mid-operation returns everything to zero.
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; read(5, 9); lit("rereset_x5_x9", 32'h0, 4'h0, 32'h0, 4'h0);

        cyc();
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

endmodule
